serial_alu_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer for the 4-bit CPU datapath.
- Time-shares one full_adder1 cell across WIDTH cycles, processing LSB first.
- Owns operand shift registers, the carry flop, a start/busy/done handshake and flag generation.
- Sits between the CPU control unit and the register file write-back path.

---
 rtl/serial_alu_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_alu_add_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_alu_add_ctrl.sv
// serial_alu_add_ctrl: bit-serial add/subtract sequencer, LSB first, one full-adder cell.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, sub        : request an operation (0 = add, 1 = subtract), sampled when accepting
//   a_in, b_in        : operands, sampled with start
//   busy, done        : busy while bits are processed, one-cycle done pulse on result update
//   result            : registered sum/difference
//   carry             : final carry-out (for subtract: 1 = no borrow)
//   overflow, zero    : signed overflow, result == 0

module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_alu_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [CW-1:0]    cnt;
    logic             sub_q, cy, fa_s, fa_c, last;

    // Subtraction feeds ~B with the carry flop preloaded to 1 (A + ~B + 1).
    full_adder1 u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0] ^ sub_q),
        .cin (cy),
        .s   (fa_s),
        .cout(fa_c)
    );

    assign last   = cnt == CW'(WIDTH - 1);
    assign sum_nx = {fa_s, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt  = state == BUSY ? (last ? DONE : BUSY) : (start ? BUSY : IDLE);
        busy = state == BUSY;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            sub_q    <= 1'b0;
            cy       <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state != BUSY && start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            sub_q <= sub;
            cy    <= sub;
            cnt   <= '0;
        end else if (state == BUSY) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nx;
            cy     <= fa_c;
            cnt    <= cnt + 1'b1;
            // On the MSB cycle the carry flop holds the carry into the MSB,
            // so overflow is that carry xor the final carry-out.
            if (last) begin
                result   <= sum_nx;
                carry    <= fa_c;
                overflow <= cy ^ fa_c;
                zero     <= sum_nx == '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_add_ctrl.sv
// tb_serial_alu_add_ctrl: scoreboard bench for serial_alu_add_ctrl with directed vectors.
module tb_serial_alu_add_ctrl;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
    logic [3:0] a_in = '0, b_in = '0, result;
    logic       busy, done, carry, overflow, zero;
    int         cyc = 0, errors = 0, checks = 0;

    typedef struct {
        logic [3:0] r;
        logic       c, v, z;
        int         at;
    } exp_t;

    exp_t q[$];

    serial_alu_add_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle=%0d got=done expected=no_done", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.at);
                chk("busy_with_done", int'(busy), 0);
                chk("result", int'(result), int'(e.r));
                chk("carry", int'(carry), int'(e.c));
                chk("overflow", int'(overflow), int'(e.v));
                chk("zero", int'(zero), int'(e.z));
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [3:0] r, input logic c, input logic v, input logic z);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
        q.push_back('{r: r, c: c, v: v, z: z, at: cyc + 5});
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        sub   = ~s;
        chk("busy_first", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("busy_last", int'(busy), 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({result, carry, overflow, zero}), 0);

        issue(4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
        issue(4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1);
        issue(4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        issue(4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0);
        issue(4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
        issue(4'd0,  4'd1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high; second op loaded in the done cycle.
        @(negedge clk);
        n = cyc;
        a_in = 4'd2; b_in = 4'd2; sub = 1'b0; start = 1'b1;
        q.push_back('{r: 4'd4, c: 1'b0, v: 1'b0, z: 1'b0, at: n + 5});
        repeat (5) @(negedge clk);
        a_in = 4'd7; b_in = 4'd7; sub = 1'b1;
        q.push_back('{r: 4'd0, c: 1'b1, v: 1'b0, z: 1'b1, at: n + 10});
        repeat (5) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_b2b", int'(busy), 0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        a_in = 4'd6; b_in = 4'd1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_outputs", int'({result, carry, overflow, zero}), 0);
        repeat (8) @(negedge clk);
        chk("abort_outputs_hold", int'({result, carry, overflow, zero}), 0);
        issue(4'd6, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
